// File: rtl/md5_pipe_core_if.sv
`default_nettype none
// ============================================================================
//  Module      : md5_pipe_core_if
//  Description : Job/result bundle between the message generator, the MD5
//                pipeline and the digest consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface md5_pipe_core_if;
    logic         en;
    logic [511:0] m_in;
    logic [15:0]  length;
    logic         valid_in;
    logic [31:0]  a_out;
    logic [31:0]  b_out;
    logic [31:0]  c_out;
    logic [31:0]  d_out;
    logic [511:0] m_out;
    logic         valid_out;

    modport master (
        output en, m_in, length, valid_in,
        input  a_out, b_out, c_out, d_out, m_out, valid_out
    );

    modport slave (
        input  en, m_in, length, valid_in,
        output a_out, b_out, c_out, d_out, m_out, valid_out
    );
endinterface
`default_nettype wire

// File: rtl/md5_pipe_core.sv
`default_nettype none
// ============================================================================
//  Module      : md5_pipe_core
//  Description : Fully pipelined single-block MD5, one round per stage,
//                one digest per enabled clock. Define MD5CORE_MOUT_EN to
//                carry the assembled block alongside its digest on m_out.
//  Revision    : 1.0 - initial release
// ============================================================================
module md5_pipe_core (
    input  wire logic      clk,
    input  wire logic      reset,
    md5_pipe_core_if.slave bus
);

    typedef logic [15:0][31:0] words_t;

    localparam logic [31:0] c_iv_a = 32'h67452301;
    localparam logic [31:0] c_iv_b = 32'hefcdab89;
    localparam logic [31:0] c_iv_c = 32'h98badcfe;
    localparam logic [31:0] c_iv_d = 32'h10325476;

    localparam logic [31:0] c_k [0:63] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };

    localparam logic [4:0] c_shift [0:15] = '{
        5'd7, 5'd12, 5'd17, 5'd22,
        5'd5, 5'd9,  5'd14, 5'd20,
        5'd4, 5'd11, 5'd16, 5'd23,
        5'd6, 5'd10, 5'd15, 5'd21
    };

    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
        return (x << s) | (x >> (6'd32 - {1'b0, s}));
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] x);
        return {x[7:0], x[15:8], x[23:16], x[31:24]};
    endfunction

    logic [511:0] w_blk;
    words_t       w_in_words;
    logic         w_unused_bits;

    logic [31:0]  a_d [0:63];
    logic [31:0]  b_d [0:63];
    logic [31:0]  c_d [0:63];
    logic [31:0]  d_d [0:63];
    words_t       m_d [0:63];
    logic [63:0]  v_d;

    logic [31:0]  a_q [0:62];
    logic [31:0]  b_q [0:62];
    logic [31:0]  c_q [0:62];
    logic [31:0]  d_q [0:62];
    words_t       m_q [0:62];
    logic [62:0]  v_q;

    logic [31:0]  a_out_d, b_out_d, c_out_d, d_out_d;
    logic [31:0]  a_out_q, b_out_q, c_out_q, d_out_q;
    logic         valid_out_d, valid_out_q;

    assign w_blk         = {bus.m_in[447:0], bus.length[7:0], bus.length[15:8], 48'h0};
    assign w_unused_bits = ^bus.m_in[511:448];

    // Byte k of the stream lands in word k/4 at byte lane k%4 (little-endian words).
    always_comb begin
        w_in_words = '0;
        for (int k = 0; k < 64; k++) begin
            w_in_words[k/4][8*(k%4) +: 8] = w_blk[511-8*k -: 8];
        end
    end

    always_comb begin : p_rounds
        logic [31:0] sa, sb, sc, sd, f, t;
        words_t      sm;
        logic        sv;
        logic [1:0]  q;
        logic [3:0]  g;
        sa = '0; sb = '0; sc = '0; sd = '0; f = '0; t = '0;
        sm = '0; sv = 1'b0; q = '0; g = '0;
        for (int i = 0; i < 64; i++) begin
            a_d[i] = '0; b_d[i] = '0; c_d[i] = '0; d_d[i] = '0; m_d[i] = '0;
        end
        v_d = '0;
        for (int i = 0; i < 64; i++) begin
            if (i == 0) begin
                sa = c_iv_a; sb = c_iv_b; sc = c_iv_c; sd = c_iv_d;
                sm = w_in_words; sv = bus.valid_in;
            end else begin
                sa = a_q[i-1]; sb = b_q[i-1]; sc = c_q[i-1]; sd = d_q[i-1];
                sm = m_q[i-1]; sv = v_q[i-1];
            end
            q = 2'(i / 16);
            case (q)
                2'd0: begin f = (sb & sc) | (~sb & sd); g = 4'(i);           end
                2'd1: begin f = (sb & sd) | (sc & ~sd); g = 4'((5*i + 1) % 16); end
                2'd2: begin f = sb ^ sc ^ sd;           g = 4'((3*i + 5) % 16); end
                default: begin f = sc ^ (sb | ~sd);     g = 4'((7*i) % 16);     end
            endcase
            t      = sa + f + c_k[i] + sm[g];
            a_d[i] = sd;
            b_d[i] = sb + rotl(t, c_shift[4*i/16 - 4*(i%16)/16 + i%4 + 0]);
            c_d[i] = sb;
            d_d[i] = sc;
            m_d[i] = sm;
            v_d[i] = sv;
        end
    end

    // Round 63 feeds the output register directly so the digest lands on the 64th edge.
    always_comb begin
        a_out_d     = bswap(c_iv_a + a_d[63]);
        b_out_d     = bswap(c_iv_b + b_d[63]);
        c_out_d     = bswap(c_iv_c + c_d[63]);
        d_out_d     = bswap(c_iv_d + d_d[63]);
        valid_out_d = v_d[63];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_q         <= '0;
            valid_out_q <= 1'b0;
            a_out_q     <= '0;
            b_out_q     <= '0;
            c_out_q     <= '0;
            d_out_q     <= '0;
        end else if (bus.en) begin
            v_q         <= v_d[62:0];
            valid_out_q <= valid_out_d;
            a_out_q     <= a_out_d;
            b_out_q     <= b_out_d;
            c_out_q     <= c_out_d;
            d_out_q     <= d_out_d;
        end
    end

    // Stage data needs no reset: it is always qualified by the stage valid bit.
    always_ff @(posedge clk) begin
        if (bus.en) begin
            for (int i = 0; i < 63; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
                c_q[i] <= c_d[i];
                d_q[i] <= d_d[i];
                m_q[i] <= m_d[i];
            end
        end
    end

`ifdef MD5CORE_MOUT_EN
    logic [511:0] m_out_d, m_out_q;

    always_comb begin
        m_out_d = '0;
        for (int k = 0; k < 64; k++) begin
            m_out_d[511-8*k -: 8] = m_d[63][k/4][8*(k%4) +: 8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_out_q <= '0;
        end else if (bus.en) begin
            m_out_q <= m_out_d;
        end
    end

    assign bus.m_out = m_out_q;
`else
    assign bus.m_out = '0;
`endif

    assign bus.a_out     = a_out_q;
    assign bus.b_out     = b_out_q;
    assign bus.c_out     = c_out_q;
    assign bus.d_out     = d_out_q;
    assign bus.valid_out = valid_out_q;

endmodule
`default_nettype wire

// File: tb/tb_md5_pipe_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md5_pipe_core
//  Description : Directed self-checking bench for md5_pipe_core.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md5_pipe_core;

    localparam logic [127:0] c_dig_fox   = 128'ha2004f37730b9445670a738fa0fc9ee5;
    localparam logic [127:0] c_dig_hello = 128'hac98cf84ae657376cea165e6729ddb39;
    localparam logic [127:0] c_dig_test  = 128'hcaea48685020e1b511a454f660943eaa;
    localparam logic [127:0] c_dig_empty = 128'hd41d8cd98f00b204e9800998ecf8427e;
    localparam int           c_timeout   = 200;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    md5_pipe_core_if bus ();

    md5_pipe_core dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [511:0] mk_msg(input string s);
        logic [511:0] m;
        m = '0;
        for (int k = 0; k < s.len(); k++) m[447-8*k -: 8] = s[k];
        m[447-8*s.len() -: 8] = 8'h80;
        return m;
    endfunction

    function automatic logic [511:0] exp_mout(input logic [511:0] m, input logic [15:0] len);
`ifdef MD5CORE_MOUT_EN
        return {m[447:0], len[7:0], len[15:8], 48'h0};
`else
        return m & 512'h0 & {496'h0, len};
`endif
    endfunction

    function automatic logic [127:0] digest();
        return {bus.a_out, bus.b_out, bus.c_out, bus.d_out};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input string s, input logic [15:0] len);
        bus.m_in     = mk_msg(s);
        bus.length   = len;
        bus.valid_in = 1'b1;
        tick();
    endtask

    // Counts enabled edges since the sampling edge (which counts as 1).
    task automatic wait_valid(inout int n);
        while (bus.valid_out !== 1'b1 && n < c_timeout) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        bus.en       = 1'b0;
        bus.valid_in = 1'b0;
        bus.m_in     = '0;
        bus.length   = '0;
        tick();
        tick();
        tests++;
        if (bus.valid_out !== 1'b0) begin
            fails++; $display("FAIL reset_valid: got %b want 0", bus.valid_out);
        end
        tests++;
        if (digest() !== 128'h0) begin
            fails++; $display("FAIL reset_digest: got %h want 0", digest());
        end
        tests++;
        if (bus.m_out !== 512'h0) begin
            fails++; $display("FAIL reset_mout: got %h want 0", bus.m_out);
        end
        reset  = 1'b0;
        bus.en = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int n;
        logic [511:0] m;
        m = mk_msg("The quick brown fox");
        send("The quick brown fox", 16'h98);
        bus.valid_in = 1'b0;
        n = 1;
        wait_valid(n);
        tests++;
        if (n !== 64) begin
            fails++; $display("FAIL single_latency: got %0d want 64", n);
        end
        tests++;
        if (digest() !== c_dig_fox) begin
            fails++; $display("FAIL single_digest: got %h want %h", digest(), c_dig_fox);
        end
        tests++;
        if (bus.m_out !== exp_mout(m, 16'h98)) begin
            fails++; $display("FAIL single_mout: got %h want %h", bus.m_out, exp_mout(m, 16'h98));
        end
        tick();
        tests++;
        if (bus.valid_out !== 1'b0) begin
            fails++; $display("FAIL single_pulse: got %b want 0", bus.valid_out);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic [127:0] want [0:2];
        want[0] = c_dig_fox; want[1] = c_dig_hello; want[2] = c_dig_test;
        send("The quick brown fox", 16'h98);
        send("Hello World 1234567", 16'h98);
        send("This is a test. 123", 16'h98);
        bus.valid_in = 1'b0;
        n = 3;
        wait_valid(n);
        tests++;
        if (n !== 64) begin
            fails++; $display("FAIL b2b_latency: got %0d want 64", n);
        end
        for (int j = 0; j < 3; j++) begin
            tests++;
            if (bus.valid_out !== 1'b1 || digest() !== want[j]) begin
                fails++;
                $display("FAIL b2b_job%0d: got v=%b %h want v=1 %h", j, bus.valid_out, digest(), want[j]);
            end
            tick();
        end
        tests++;
        if (bus.valid_out !== 1'b0) begin
            fails++; $display("FAIL b2b_tail: got %b want 0", bus.valid_out);
        end
    endtask

    task automatic test_empty();
        int n;
        send("", 16'h0);
        bus.valid_in = 1'b0;
        n = 1;
        wait_valid(n);
        tests++;
        if (n !== 64 || digest() !== c_dig_empty) begin
            fails++; $display("FAIL empty: got n=%0d %h want n=64 %h", n, digest(), c_dig_empty);
        end
    endtask

    task automatic test_stall();
        int n;
        int bad;
        send("Hello World 1234567", 16'h98);
        bus.valid_in = 1'b0;
        n = 1;
        repeat (29) begin tick(); n++; end
        bus.en = 1'b0;
        bad = 0;
        repeat (10) begin
            tick();
            if (bus.valid_out !== 1'b0) bad++;
        end
        tests++;
        if (bad !== 0) begin
            fails++; $display("FAIL stall_frozen: got %0d early valid cycles want 0", bad);
        end
        bus.en = 1'b1;
        wait_valid(n);
        tests++;
        if (n !== 64 || digest() !== c_dig_hello) begin
            fails++; $display("FAIL stall_result: got n=%0d %h want n=64 %h", n, digest(), c_dig_hello);
        end
        bus.en = 1'b0;
        repeat (3) tick();
        tests++;
        if (bus.valid_out !== 1'b1 || digest() !== c_dig_hello) begin
            fails++; $display("FAIL stall_hold: got v=%b %h want v=1 %h", bus.valid_out, digest(), c_dig_hello);
        end
        bus.en = 1'b1;
        tick();
        tests++;
        if (bus.valid_out !== 1'b0) begin
            fails++; $display("FAIL stall_release: got %b want 0", bus.valid_out);
        end
    endtask

    task automatic test_reset_midflight();
        int stale;
        send("The quick brown fox", 16'h98);
        send("Hello World 1234567", 16'h98);
        send("This is a test. 123", 16'h98);
        bus.valid_in = 1'b0;
        repeat (10) tick();
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if (bus.valid_out !== 1'b0 || digest() !== 128'h0 || bus.m_out !== 512'h0) begin
            fails++;
            $display("FAIL midreset_clear: got v=%b %h want v=0 0", bus.valid_out, digest());
        end
        tick();
        reset = 1'b0;
        stale = 0;
        repeat (80) begin
            tick();
            if (bus.valid_out !== 1'b0) stale++;
        end
        tests++;
        if (stale !== 0) begin
            fails++; $display("FAIL midreset_stale: got %0d valid cycles want 0", stale);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_empty();
        test_stall();
        test_reset_midflight();
        test_single();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
